cnn_conv_stream: RTL and testbench

// Parametrised streaming 2-D convolution engine, the next generation of the fixed 8x8/3x3 CNN core.
// - Image size, kernel size, data and accumulator widths are set by parameters.
// - Kernel coefficients are loaded at run time over a write port.
// - Pixels arrive over a valid/ready stream in raster order; results leave over a valid/ready stream.
// - ReLU is selectable at run time.

---
 rtl/cnn_conv_stream_if.sv | 12 +
 rtl/cnn_conv_stream.sv | 208 ++++++++++++++++++++
 tb/tb_cnn_conv_stream.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_conv_stream_if.sv
// cnn_conv_stream_if: valid/ready data stream used for the pixel input
// and the result output of the convolution engine.
interface cnn_conv_stream_if #(
    parameter int W = 16
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/cnn_conv_stream.sv
// cnn_conv_stream: streaming valid-padding 2-D convolution with a K-row
// circular line buffer and one multiply-accumulate per cycle.
module cnn_conv_stream #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int DATA_W = 16,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 32,
    localparam int AW    = (K > 1) ? $clog2(K * K) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_relu_en,
    input  logic                     i_coef_we,
    input  logic [AW-1:0]            i_coef_addr,
    input  logic signed [COEF_W-1:0] i_coef_data,
    cnn_conv_stream_if.slave         s_pix,
    cnn_conv_stream_if.master        m_out,
    output logic                     o_out_last,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int OW  = IMG_W - K + 1;
    localparam int OH  = IMG_H - K + 1;
    localparam int NT  = K * K;
    localparam int RW  = (K > 1) ? $clog2(K) : 1;
    localparam int RW1 = RW + 1;
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int HW  = (OH > 1) ? $clog2(OH) : 1;
    localparam int PW  = DATA_W + COEF_W;

    localparam logic [RW-1:0] KM1  = RW'(K - 1);
    localparam logic [RW:0]   KS   = RW1'(K);
    localparam logic [CW-1:0] WM1  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] OWM1 = CW'(OW - 1);
    localparam logic [HW-1:0] OHM1 = HW'(OH - 1);
    localparam logic [AW-1:0] TM1  = AW'(NT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_MAC, S_EMIT, S_ROW, S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [DATA_W-1:0] r_lb   [K][IMG_W];
    logic signed [COEF_W-1:0] r_coef [NT];

    logic [RW-1:0]           r_top;
    logic [RW-1:0]           r_wrow;
    logic [RW-1:0]           r_kr;
    logic [RW-1:0]           r_kc;
    logic [CW-1:0]           r_wcol;
    logic [CW-1:0]           r_col;
    logic [HW-1:0]           r_orow;
    logic [AW-1:0]           r_tap;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_out;
    logic                    r_last;
    logic                    r_relu;

    logic                    w_pix_xfer;
    logic                    w_out_xfer;
    logic [RW:0]             w_ssum;
    logic [RW-1:0]           w_slot;
    logic [RW-1:0]           w_wslot;
    logic [RW-1:0]           w_top_nx;
    logic [CW-1:0]           w_pcol;
    logic signed [PW-1:0]    w_pix_x;
    logic signed [PW-1:0]    w_coef_x;
    logic signed [PW-1:0]    w_prod;
    logic signed [ACC_W-1:0] w_sum;

    assign s_pix.ready = (r_state == S_FILL) || (r_state == S_ROW);
    assign m_out.valid = (r_state == S_EMIT);
    assign m_out.data  = r_out;
    assign o_out_last  = r_last;
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done      = (r_state == S_DONE);

    assign w_pix_xfer = s_pix.valid && s_pix.ready;
    assign w_out_xfer = m_out.valid && m_out.ready;

    // Window row kr lives in physical slot (top + kr) mod K.
    assign w_ssum   = {1'b0, r_top} + {1'b0, r_kr};
    assign w_slot   = (w_ssum >= KS) ? RW'(w_ssum - KS) : RW'(w_ssum);
    assign w_top_nx = (r_top == KM1) ? '0 : r_top + 1'b1;
    assign w_wslot  = (r_state == S_FILL) ? r_wrow : r_top;
    assign w_pcol   = r_col + CW'(r_kc);

    assign w_pix_x  = PW'(r_lb[w_slot][w_pcol]);
    assign w_coef_x = PW'(r_coef[r_tap]);
    assign w_prod   = w_pix_x * w_coef_x;
    assign w_sum    = r_acc + ACC_W'(w_prod);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (i_start) w_next = S_FILL;
            S_FILL: begin
                if (w_pix_xfer && r_wcol == WM1 && r_wrow == KM1)
                    w_next = S_MAC;
            end
            S_MAC:  if (r_tap == TM1) w_next = S_EMIT;
            S_EMIT: begin
                if (w_out_xfer) begin
                    if (r_col != OWM1)
                        w_next = S_MAC;
                    else if (r_orow != OHM1)
                        w_next = S_ROW;
                    else
                        w_next = S_DONE;
                end
            end
            S_ROW:  if (w_pix_xfer && r_wcol == WM1) w_next = S_MAC;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_pix_xfer) r_lb[w_wslot][r_wcol] <= s_pix.data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_top   <= '0;
            r_wrow  <= '0;
            r_kr    <= '0;
            r_kc    <= '0;
            r_wcol  <= '0;
            r_col   <= '0;
            r_orow  <= '0;
            r_tap   <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_last  <= 1'b0;
            r_relu  <= 1'b0;
            for (int i = 0; i < NT; i++) r_coef[i] <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (i_coef_we && i_coef_addr <= TM1)
                        r_coef[i_coef_addr] <= i_coef_data;
                    if (i_start) begin
                        r_relu <= i_relu_en;
                        r_top  <= '0;
                        r_wrow <= '0;
                        r_wcol <= '0;
                        r_col  <= '0;
                        r_orow <= '0;
                    end
                end
                S_FILL: begin
                    if (w_pix_xfer) begin
                        if (r_wcol == WM1) begin
                            r_wcol <= '0;
                            r_wrow <= (r_wrow == KM1) ? '0 : r_wrow + 1'b1;
                        end else begin
                            r_wcol <= r_wcol + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    if (r_tap == TM1) begin
                        r_tap  <= '0;
                        r_kr   <= '0;
                        r_kc   <= '0;
                        r_acc  <= '0;
                        r_out  <= (r_relu && w_sum[ACC_W-1]) ? '0 : w_sum;
                        r_last <= (r_col == OWM1) && (r_orow == OHM1);
                    end else begin
                        r_tap <= r_tap + 1'b1;
                        r_acc <= w_sum;
                        if (r_kc == KM1) begin
                            r_kc <= '0;
                            r_kr <= r_kr + 1'b1;
                        end else begin
                            r_kc <= r_kc + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_out_xfer)
                        r_col <= (r_col == OWM1) ? '0 : r_col + 1'b1;
                end
                S_ROW: begin
                    // New row overwrites the oldest slot, which then becomes the newest.
                    if (w_pix_xfer) begin
                        if (r_wcol == WM1) begin
                            r_wcol <= '0;
                            r_top  <= w_top_nx;
                            r_orow <= r_orow + 1'b1;
                        end else begin
                            r_wcol <= r_wcol + 1'b1;
                        end
                    end
                end
                S_DONE: r_last <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_conv_stream.sv
// tb_cnn_conv_stream: randomized stream bench with an arithmetic reference
// model, plus a 3x3 image / 3x3 kernel single-result instance.
module tb_cnn_conv_stream;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int KK   = 3;
    localparam int DW   = 16;
    localparam int CWD  = 8;
    localparam int AWD  = 32;
    localparam int OW   = W - KK + 1;
    localparam int OH   = H - KK + 1;
    localparam int NR   = OW * OH;
    localparam int TAPS = KK * KK;
    localparam int CAW  = $clog2(TAPS);
    localparam longint SMALL_EXP = 9 * 32767 * 127;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic                  start, relu_en, coef_we;
    logic [CAW-1:0]        coef_addr;
    logic signed [CWD-1:0] coef_data;
    logic                  out_last, busy, done;

    logic                  s_start, s_relu, s_cwe;
    logic [CAW-1:0]        s_caddr;
    logic signed [CWD-1:0] s_cdata;
    logic                  s_last, s_busy, s_done;

    cnn_conv_stream_if #(.W(DW))  pix_if();
    cnn_conv_stream_if #(.W(AWD)) out_if();
    cnn_conv_stream_if #(.W(DW))  s_pix_if();
    cnn_conv_stream_if #(.W(AWD)) s_out_if();

    cnn_conv_stream #(
        .IMG_W(W), .IMG_H(H), .K(KK),
        .DATA_W(DW), .COEF_W(CWD), .ACC_W(AWD)
    ) dut (
        .clk(clk), .rst(rst),
        .i_start(start), .i_relu_en(relu_en),
        .i_coef_we(coef_we), .i_coef_addr(coef_addr),
        .i_coef_data(coef_data),
        .s_pix(pix_if), .m_out(out_if),
        .o_out_last(out_last), .o_busy(busy), .o_done(done)
    );

    cnn_conv_stream #(
        .IMG_W(3), .IMG_H(3), .K(3),
        .DATA_W(DW), .COEF_W(CWD), .ACC_W(AWD)
    ) dut_small (
        .clk(clk), .rst(rst),
        .i_start(s_start), .i_relu_en(s_relu),
        .i_coef_we(s_cwe), .i_coef_addr(s_caddr),
        .i_coef_data(s_cdata),
        .s_pix(s_pix_if), .m_out(s_out_if),
        .o_out_last(s_last), .o_busy(s_busy), .o_done(s_done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int img  [W*H];
    int coef [TAPS];

    logic [DW-1:0]  pix_q  [$];
    logic [AWD-1:0] exp_q  [$];
    bit             last_q [$];

    bit   pix_pend = 1'b0;
    int   gap_pct  = 0;
    bit   stall_mode = 1'b0;
    int   n_pix = 0, n_res = 0, n_done = 0;
    int   fill_edge = 0, last_edge = 0, wait_cnt = 0, idx = 0;
    bit   prev_v = 1'b0, prev_x = 1'b0;
    logic [AWD-1:0] prev_d = '0;
    logic prev_l = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Reference: direct valid-padding convolution of the whole frame.
    function automatic void model(input bit relu);
        for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
                longint s = 0;
                logic [AWD-1:0] v;
                for (int i = 0; i < KK; i++)
                    for (int j = 0; j < KK; j++)
                        s += longint'(img[(r+i)*W + c + j]) * longint'(coef[i*KK + j]);
                v = s[AWD-1:0];
                if (relu && v[AWD-1]) v = '0;
                exp_q.push_back(v);
                last_q.push_back(r*OW + c == NR - 1);
            end
        end
    endfunction

    initial begin : pix_drv
        pix_if.valid = 1'b0;
        pix_if.data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pix_q.delete();
                pix_pend     = 1'b0;
                pix_if.valid = 1'b0;
            end else begin
                if (pix_pend) void'(pix_q.pop_front());
                pix_if.valid = (pix_q.size() > 0) &&
                               (int'($urandom_range(99)) >= gap_pct);
                pix_if.data  = (pix_q.size() > 0) ? pix_q[0] : '0;
                pix_pend     = pix_if.valid && pix_if.ready;
                if (pix_pend) begin
                    n_pix++;
                    if (n_pix == KK * W) fill_edge = cyc + 1;
                end
            end
        end
    end

    initial begin : out_mon
        out_if.ready = 1'b0;
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (rst) begin
                prev_v   = 1'b0;
                prev_x   = 1'b0;
                wait_cnt = 0;
            end else begin
                if (prev_v && !prev_x) begin
                    check("out_valid held", out_if.valid, 1);
                    check("out_data stable", out_if.data, prev_d);
                    check("out_last stable", out_last, prev_l);
                end
                if (out_if.valid) begin
                    out_if.ready = !stall_mode || (wait_cnt >= 5);
                    wait_cnt++;
                end else begin
                    out_if.ready = !stall_mode;
                    wait_cnt = 0;
                end
                prev_x = out_if.valid && out_if.ready;
                if (prev_x) begin
                    wait_cnt = 0;
                    check("result expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        idx = n_res;
                        n_res++;
                        check("out_data", out_if.data, exp_q.pop_front());
                        check("out_last", out_last, last_q.pop_front());
                        if (!stall_mode && idx == 0)
                            check("first latency", cyc + 1 - fill_edge, TAPS + 1);
                        if (!stall_mode && idx % OW != 0)
                            check("result interval", cyc + 1 - last_edge, TAPS + 1);
                    end
                    last_edge = cyc + 1;
                end
                prev_v = out_if.valid;
                prev_d = out_if.data;
                prev_l = out_last;
            end
        end
    end

    task automatic load_coefs();
        for (int t = 0; t < TAPS; t++) begin
            coef_we   = 1'b1;
            coef_addr = CAW'(t);
            coef_data = CWD'(coef[t]);
            tick(1);
        end
        coef_we = 1'b0;
    endtask

    task automatic start_frame(input bit relu, input bit stall, input int gaps);
        exp_q.delete();
        last_q.delete();
        model(relu);
        for (int i = 0; i < W*H; i++) pix_q.push_back(DW'(img[i]));
        n_pix = 0; n_res = 0; n_done = 0;
        stall_mode = stall;
        gap_pct    = gaps;
        relu_en = relu;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
        relu_en = !relu;
    endtask

    task automatic wait_frame();
        int t = 0;
        while (!(n_done > 0 && exp_q.size() == 0) && t < 20000) begin
            tick(1);
            t++;
        end
        check("frame completes", t < 20000, 1);
        tick(4);
        check("done pulses", n_done, 1);
        check("results left", exp_q.size(), 0);
        check("busy after done", busy, 0);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < W*H; i++) img[i] = i;
    endtask

    task automatic run_small();
        int cnt = 0;
        int t = 0;
        bit xfer;
        for (int i = 0; i < TAPS; i++) begin
            s_cwe   = 1'b1;
            s_caddr = CAW'(i);
            s_cdata = 8'sh7F;
            tick(1);
        end
        s_cwe   = 1'b0;
        s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        s_pix_if.valid = 1'b1;
        s_pix_if.data  = 16'h7FFF;
        while (cnt < 9 && t < 200) begin
            xfer = s_pix_if.ready;
            tick(1);
            if (xfer) cnt++;
            t++;
        end
        s_pix_if.valid = 1'b0;
        check("small pixels taken", cnt, 9);
        t = 0;
        while (!s_out_if.valid && t < 200) begin
            tick(1);
            t++;
        end
        check("small valid", s_out_if.valid, 1);
        check("small result", s_out_if.data, SMALL_EXP);
        check("small last", s_last, 1);
        tick(3);
        check("small stable", s_out_if.data, SMALL_EXP);
        check("small held", s_out_if.valid, 1);
        s_out_if.ready = 1'b1;
        tick(1);
        s_out_if.ready = 1'b0;
        check("small done", s_done, 1);
        check("small valid drop", s_out_if.valid, 0);
        tick(1);
        check("small done pulse", s_done, 0);
        check("small busy", s_busy, 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        rst = 1'b1; start = 1'b0; relu_en = 1'b0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0;
        s_start = 1'b0; s_relu = 1'b0; s_cwe = 1'b0;
        s_caddr = '0; s_cdata = '0;
        s_pix_if.valid = 1'b0; s_pix_if.data = '0; s_out_if.ready = 1'b0;
        tick(3);
        check("rst pix_ready", pix_if.ready, 0);
        check("rst out_valid", out_if.valid, 0);
        check("rst out_data", out_if.data, 0);
        check("rst out_last", out_last, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        rst = 1'b0;
        tick(2);

        // Centre tap identity, plain ramp
        set_ramp();
        coef = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_coefs();
        start_frame(1'b0, 1'b0, 0);
        check("model first", exp_q[0], 9);
        check("model row0 end", exp_q[5], 14);
        check("model row1 start", exp_q[6], 17);
        check("model last", exp_q[NR-1], 54);
        check("busy in frame", busy, 1);
        wait_frame();

        // Vertical edge kernel and its negation
        coef = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
        load_coefs();
        start_frame(1'b1, 1'b0, 0);
        check("model edge", exp_q[0], 48);
        check("model edge last", exp_q[NR-1], 48);
        wait_frame();
        coef = '{1, 1, 1, 0, 0, 0, -1, -1, -1};
        load_coefs();
        start_frame(1'b1, 1'b0, 10);
        check("model neg relu", exp_q[17], 0);
        wait_frame();
        start_frame(1'b0, 1'b0, 10);
        check("model neg raw", exp_q[20], 32'hFFFF_FFD0);
        wait_frame();

        // Backpressure plus input gaps
        coef = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_coefs();
        start_frame(1'b0, 1'b1, 35);
        wait_frame();

        // Coefficient write and start while busy must be ignored
        start_frame(1'b0, 1'b0, 0);
        tick(20);
        coef_we = 1'b1; coef_addr = CAW'(4); coef_data = 8'sd7;
        start = 1'b1;
        tick(3);
        coef_we = 1'b0;
        start = 1'b0;
        wait_frame();
        tick(10);
        check("no restart busy", busy, 0);
        check("no restart valid", out_if.valid, 0);

        // Reset mid-frame after 10 results
        start_frame(1'b0, 1'b0, 20);
        begin
            int t = 0;
            while (n_res < 10 && t < 5000) begin
                tick(1);
                t++;
            end
        end
        check("ten results", n_res, 10);
        rst = 1'b1;
        tick(2);
        exp_q.delete();
        last_q.delete();
        tick(1);
        rst = 1'b0;
        tick(1);
        check("post-rst out_valid", out_if.valid, 0);
        check("post-rst busy", busy, 0);
        check("post-rst pix_ready", pix_if.ready, 0);
        tick(5);
        check("post-rst no stale", out_if.valid, 0);
        coef = '{default: 0};
        start_frame(1'b0, 1'b0, 0);
        wait_frame();
        coef = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_coefs();
        start_frame(1'b0, 1'b0, 15);
        wait_frame();

        // Random images and kernels
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < W*H; i++) img[i] = int'($signed(16'($urandom)));
            for (int i = 0; i < TAPS; i++) coef[i] = int'($signed(8'($urandom)));
            load_coefs();
            start_frame(1'($urandom_range(1)), 1'(n == 2), 30);
            wait_frame();
        end

        // Degenerate single-result configuration
        run_small();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
